// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Each request is served as a three-cycle sequence: IDLE (grant) -> ACCESS
// (memory strobe) -> RESP (capture read data), with the ACK pulse appearing in
// the first IDLE cycle afterwards.
//
// Ports
//   CK              clock, rising edge
//   RST             synchronous active-high reset
//   REQ0/REQ1       access requests, held until the matching ACK
//   WE0/WE1         1 = write, 0 = read
//   ADDR0/ADDR1     access addresses
//   WDATA0/WDATA1   write data
//   ACK0/ACK1       one-cycle completion pulses
//   RDATA           read data, valid in the ACK cycle of a read, then held
//   MEN             memory strobe (high only in the ACCESS cycle)
//   MRW             memory direction, 1 = read, 0 = write
//   MA              memory address
//   MWD             memory write data
//   MRD             memory read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          MEN,
    output logic          MRW,
    output logic [AW-1:0] MA,
    output logic [DW-1:0] MWD,
    input  logic [DW-1:0] MRD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg;
    logic   grant_reg;   // port currently being served
    logic   we_reg;      // direction of the access in flight
    logic   last_reg;    // port served most recently

    logic          elig0;
    logic          elig1;
    logic          any_elig;
    logic          winner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // A request that is still high during its own ACK cycle is the tail of the
    // access just completed, not a new one.
    assign elig0    = REQ0 & ~ACK0;
    assign elig1    = REQ1 & ~ACK1;
    assign any_elig = elig0 | elig1;

    // On a tie the port that was not served last wins; otherwise the only
    // eligible port wins (elig1 alone selects port 1, elig0 alone port 0).
    assign winner = (elig0 & elig1) ? ~last_reg : elig1;

    assign sel_we    = winner ? WE1    : WE0;
    assign sel_addr  = winner ? ADDR1  : ADDR0;
    assign sel_wdata = winner ? WDATA1 : WDATA0;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            we_reg    <= 1'b0;
            last_reg  <= 1'b1;
            MEN       <= 1'b0;
            MRW       <= 1'b1;
            MA        <= '0;
            MWD       <= '0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            RDATA     <= '0;
        end else begin
            // Strobe, write direction and ACKs are single-cycle pulses; they
            // fall back to their quiet values unless a state below sets them.
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            MEN  <= 1'b0;
            MRW  <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (any_elig) begin
                        grant_reg <= winner;
                        we_reg    <= sel_we;
                        MEN       <= 1'b1;
                        MRW       <= ~sel_we;
                        MA        <= sel_addr;
                        MWD       <= sel_wdata;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    // MRD now carries the data for the strobe of the ACCESS cycle.
                    if (!we_reg) begin
                        RDATA <= MRD;
                    end
                    if (grant_reg) begin
                        ACK1 <= 1'b1;
                    end else begin
                        ACK0 <= 1'b1;
                    end
                    last_reg  <= grant_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter: directed multi-cycle sequences, a table
// of single transactions, and a randomized two-port run compared cycle by
// cycle against a transaction-level reference model. A small synchronous
// memory model is attached to the memory port.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          CK;
    logic          RST;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    ack;
    logic [DW-1:0] RDATA;
    logic          MEN;
    logic          MRW;
    logic [AW-1:0] MA;
    logic [DW-1:0] MWD;
    logic [DW-1:0] MRD;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .CK     (CK),
        .RST    (RST),
        .REQ0   (req[0]),
        .REQ1   (req[1]),
        .WE0    (we[0]),
        .WE1    (we[1]),
        .ADDR0  (addr[0]),
        .ADDR1  (addr[1]),
        .WDATA0 (wdata[0]),
        .WDATA1 (wdata[1]),
        .ACK0   (ack[0]),
        .ACK1   (ack[1]),
        .RDATA  (RDATA),
        .MEN    (MEN),
        .MRW    (MRW),
        .MA     (MA),
        .MWD    (MWD),
        .MRD    (MRD)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Memory device: write on a write strobe, read data one cycle after a
    // read strobe.
    logic [DW-1:0] mem_dev [0:65535];
    always @(posedge CK) begin
        if (MEN) begin
            if (!MRW) mem_dev[MA] <= MWD;
            else      MRD <= mem_dev[MA];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Global properties: never two ACKs at once, never a write direction
    // outside a strobe cycle.
    always @(negedge CK) begin
        if (mon_en && !RST) begin
            chk("ack_mutex", {31'd0, ack[0] & ack[1]}, 32'd0);
            chk("mrw_outside_access", {31'd0, ~MEN & ~MRW}, 32'd0);
        end
    end

    task automatic do_reset();
        @(negedge CK);
        req = 2'b00;
        RST = 1'b1;
        @(negedge CK);
        @(negedge CK);
        RST = 1'b0;
    endtask

    // Waits for ACK of port p, counting falling edges from now.
    task automatic wait_ack(input int p, output int lat, output bit got);
        lat = 0;
        got = 0;
        while (!got && lat < 12) begin
            @(negedge CK);
            lat++;
            if (ack[p]) got = 1;
        end
    endtask

    // One isolated transaction on port p, checked for strobe shape, latency
    // and the resulting RDATA.
    task automatic single(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                          input string nm);
        int lat = 0;
        int men_cnt = 0;
        bit got = 0;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        while (!got && lat < 12) begin
            @(negedge CK);
            lat++;
            if (MEN) begin
                men_cnt++;
                chk({nm, "_ma"}, {16'd0, MA}, {16'd0, a});
                chk({nm, "_mrw"}, {31'd0, MRW}, {31'd0, ~w});
                if (w) chk({nm, "_mwd"}, {16'd0, MWD}, {16'd0, d});
            end
            if (ack[p]) got = 1;
        end
        chk({nm, "_ack_seen"}, {31'd0, got}, 32'd1);
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_men_cycles"}, men_cnt, 1);
        chk({nm, "_other_ack"}, {31'd0, ack[1-p]}, 32'd0);
        chk({nm, "_rdata"}, {16'd0, RDATA}, {16'd0, exp_rd});
        req[p] = 1'b0;
        @(negedge CK);
        chk({nm, "_ack_pulse"}, {31'd0, ack[p]}, 32'd0);
    endtask

    typedef struct {
        int            port;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the randomized run.
    logic [DW-1:0] mem_m [0:15];

    initial begin
        int lat;
        bit got;
        int ack_port [16];
        int ack_cyc  [16];
        logic [AW-1:0] ma_seen [16];
        int n_ack;
        int n_men;
        int men_cnt;

        tbl[0] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[1] = '{1, 1'b1, 16'h00FF, 16'h1234, 16'hBEEF};
        tbl[2] = '{1, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
        tbl[3] = '{0, 1'b1, 16'h0000, 16'hFFFF, 16'h1234};
        tbl[4] = '{0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
        tbl[5] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
        tbl[6] = '{1, 1'b1, 16'h0010, 16'h0000, 16'h0001};
        tbl[7] = '{0, 1'b0, 16'h0010, 16'h0000, 16'h0000};

        for (int i = 0; i < 65536; i++) mem_dev[i] = '0;
        mem_dev[16'h0010] = 16'hBEEF;
        mem_dev[16'h0020] = 16'h5A5A;
        mem_dev[16'hFFFF] = 16'h0001;

        RST = 1'b1; req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Reset values and idle stability.
        do_reset();
        mon_en = 1;
        chk("rst_men", {31'd0, MEN}, 32'd0);
        chk("rst_mrw", {31'd0, MRW}, 32'd1);
        chk("rst_ma", {16'd0, MA}, 32'd0);
        chk("rst_mwd", {16'd0, MWD}, 32'd0);
        chk("rst_acks", {30'd0, ack}, 32'd0);
        chk("rst_rdata", {16'd0, RDATA}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            chk("idle_quiet", {28'd0, MEN, MRW, ack}, 32'h4);
        end

        // Both ports saturated right after reset: 0,1,0,1 three cycles apart.
        do_reset();
        we = 2'b00; addr[0] = 16'h0010; addr[1] = 16'h0020; req = 2'b11;
        n_ack = 0; n_men = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CK);
            if (MEN && n_men < 16) begin ma_seen[n_men] = MA; n_men++; end
            if ((ack[0] || ack[1]) && n_ack < 16) begin
                ack_port[n_ack] = ack[1] ? 1 : 0;
                ack_cyc[n_ack] = c;
                chk("sat_rdata", {16'd0, RDATA}, ack[1] ? 32'h5A5A : 32'hBEEF);
                n_ack++;
            end
        end
        chk("sat_ack_count", n_ack, 10);
        for (int k = 0; k < 8; k++) begin
            chk("sat_order", ack_port[k], k % 2);
            chk("sat_spacing", ack_cyc[k], 3 + 3 * k);
            chk("sat_ma", {16'd0, ma_seen[k]}, (k % 2) ? 32'h0020 : 32'h0010);
        end
        req = 2'b00;
        repeat (6) @(negedge CK);

        // REQ0 held through the edge that ends its ACK cycle: no second access.
        do_reset();
        we[0] = 1'b0; addr[0] = 16'h0020; req[0] = 1'b1;
        wait_ack(0, lat, got);
        chk("hold_ack0", {31'd0, got}, 32'd1);
        @(posedge CK);
        #1 req[0] = 1'b0;
        men_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CK);
            if (MEN) men_cnt++;
            if (ack[0]) men_cnt++;
        end
        chk("hold_no_reaccess", men_cnt, 0);

        // Same, with REQ1 pending: port 1 is served straight after.
        do_reset();
        we = 2'b00; addr[0] = 16'h0020; addr[1] = 16'h0010; req[0] = 1'b1;
        @(negedge CK);
        req[1] = 1'b1;
        wait_ack(0, lat, got);
        chk("hold2_ack0", {31'd0, got}, 32'd1);
        @(posedge CK);
        #1 req[0] = 1'b0;
        wait_ack(1, lat, got);
        chk("hold2_ack1_seen", {31'd0, got}, 32'd1);
        chk("hold2_ack1_latency", lat, 3);
        chk("hold2_rdata", {16'd0, RDATA}, 32'hBEEF);
        req[1] = 1'b0;
        men_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CK);
            if (MEN || ack[0] || ack[1]) men_cnt++;
        end
        chk("hold2_quiet_after", men_cnt, 0);

        // Reset during ACCESS aborts the read; the held request is then served.
        do_reset();
        we[0] = 1'b0; addr[0] = 16'h0020; req[0] = 1'b1;
        @(negedge CK);
        chk("abort_men_before", {31'd0, MEN}, 32'd1);
        RST = 1'b1;
        @(negedge CK);
        chk("abort_men", {31'd0, MEN}, 32'd0);
        chk("abort_ack0", {31'd0, ack[0]}, 32'd0);
        chk("abort_rdata", {16'd0, RDATA}, 32'd0);
        RST = 1'b0;
        wait_ack(0, lat, got);
        chk("abort_retry_seen", {31'd0, got}, 32'd1);
        chk("abort_retry_latency", lat, 3);
        chk("abort_retry_rdata", {16'd0, RDATA}, 32'h5A5A);
        req[0] = 1'b0;
        @(negedge CK);

        // Table of isolated transactions.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            single(tbl[i].port, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd,
                   $sformatf("tbl%0d", i));
        end

        // Randomized two-port traffic against the reference model.
        do_reset();
        begin
            int            busy;       // edges until the arbiter can grant again
            int            cur_p;
            logic          cur_w;
            logic [AW-1:0] cur_a;
            logic [DW-1:0] cur_d;
            int            last_served;
            logic [DW-1:0] m_rdata;
            logic [1:0]    e_ack;
            logic          e_men;
            logic          e_mrw;
            logic [AW-1:0] e_ma;
            logic [DW-1:0] e_mwd;
            bit            hold [2];
            bit            drop_next [2];
            int            cool [2];
            int            n_done;

            for (int i = 0; i < 16; i++) mem_m[i] = mem_dev[i];
            busy = 0; cur_p = 0; cur_w = 0; cur_a = '0; cur_d = '0;
            last_served = 1; m_rdata = '0; e_ack = 2'b00;
            e_men = 0; e_mrw = 1; e_ma = '0; e_mwd = '0; n_done = 0;
            for (int p = 0; p < 2; p++) begin hold[p] = 0; drop_next[p] = 0; cool[p] = 0; end

            for (int cyc = 0; cyc < 800; cyc++) begin
                // Requesters.
                for (int p = 0; p < 2; p++) begin
                    if (req[p]) begin
                        if (ack[p]) begin
                            if (hold[p]) drop_next[p] = 1;
                            else begin req[p] = 0; cool[p] = int'($urandom_range(0, 2)); end
                        end else if (drop_next[p]) begin
                            req[p] = 0; drop_next[p] = 0; cool[p] = int'($urandom_range(0, 2));
                        end
                    end else if (cool[p] > 0) begin
                        cool[p]--;
                    end else if ($urandom_range(0, 1) == 1) begin
                        we[p] = $urandom_range(0, 1) == 1;
                        addr[p] = AW'($urandom_range(0, 15));
                        wdata[p] = DW'($urandom);
                        hold[p] = $urandom_range(0, 3) == 0;
                        req[p] = 1;
                    end
                end

                // Reference model: what the coming edge must produce.
                begin
                    logic [1:0] n_ack_v;
                    bit w0, w1;
                    n_ack_v = 2'b00;
                    e_men = 0;
                    e_mrw = 1;
                    if (busy == 0) begin
                        w0 = req[0] && !e_ack[0];
                        w1 = req[1] && !e_ack[1];
                        if (w0 || w1) begin
                            if (w0 && w1) cur_p = 1 - last_served;
                            else          cur_p = w1 ? 1 : 0;
                            cur_w = we[cur_p]; cur_a = addr[cur_p]; cur_d = wdata[cur_p];
                            e_men = 1; e_mrw = !cur_w; e_ma = cur_a; e_mwd = cur_d;
                            busy = 2;
                        end
                    end else if (busy == 2) begin
                        busy = 1;
                    end else begin
                        busy = 0;
                        n_ack_v[cur_p] = 1'b1;
                        if (cur_w) mem_m[cur_a[3:0]] = cur_d;
                        else       m_rdata = mem_m[cur_a[3:0]];
                        last_served = cur_p;
                        n_done++;
                    end
                    e_ack = n_ack_v;
                end

                @(negedge CK);
                chk("rnd_ack", {30'd0, ack}, {30'd0, e_ack});
                chk("rnd_men", {31'd0, MEN}, {31'd0, e_men});
                chk("rnd_rdata", {16'd0, RDATA}, {16'd0, m_rdata});
                if (e_men) begin
                    chk("rnd_ma", {16'd0, MA}, {16'd0, e_ma});
                    chk("rnd_mrw", {31'd0, MRW}, {31'd0, e_mrw});
                    if (!e_mrw) chk("rnd_mwd", {16'd0, MWD}, {16'd0, e_mwd});
                end
            end
            chk("rnd_progress", {31'd0, n_done > 50}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, address width of requester and memory ports.
REQ-002 Parameter DW, default 16, data width of requester and memory ports.
REQ-003 CK  input  1  clock; every register updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ0, REQ1  input  1 each  access request from port 0 and port 1; held high until that port's ACK.
REQ-006 WE0, WE1  input  1 each  1 = write, 0 = read; stable while REQ is high.
REQ-007 ADDR0, ADDR1  input  AW each  access address; stable while REQ is high.
REQ-008 WDATA0, WDATA1  input  DW each  write data; stable while REQ is high.
REQ-009 ACK0, ACK1  output  1 each  one-cycle completion pulse per port.
REQ-010 RDATA  output  DW  read data; valid in the ACK cycle of a read.
REQ-011 MEN  output  1  memory access strobe.
REQ-012 MRW  output  1  memory direction: 1 = read, 0 = write.
REQ-013 MA  output  AW  memory address.
REQ-014 MWD  output  DW  memory write data.
REQ-015 MRD  input  DW  memory read data, valid the cycle after a read strobe.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-017 IDLE with no eligible request: stay IDLE, MEN=0.
REQ-018 IDLE with an eligible request: latch grant, WE, ADDR and WDATA of the winner, then go to ACCESS.
REQ-019 Eligible means REQx=1 and ACKx=0 in the same cycle; a REQ still high during its own ACK cycle is ignored.
REQ-020 Arbitration SHALL be round-robin on register LAST (last port served): both requests eligible -> port != LAST wins; single request -> that port wins.
REQ-021 ACCESS: MEN=1, MA=latched address, MRW=~latched WE, MWD=latched write data, all registered outputs valid for exactly this cycle; next state RESP.
REQ-022 RESP: MEN=0, MRW=1; on the edge leaving RESP, RDATA<=MRD if the access was a read (unchanged on write), ACK of the granted port <=1, LAST<=granted port; next state IDLE.
REQ-023 ACK SHALL be high for exactly one cycle (the first IDLE cycle after RESP), with at most one ACK high at any time.
REQ-024 Latency: REQ first sampled in IDLE at edge N -> ACK high during cycle N+3; peak throughput one access per 3 cycles; with both ports saturated, grants SHALL alternate 0,1,0,1.
REQ-025 A REQ change during ACCESS/RESP SHALL NOT affect the access in flight.
REQ-026 MRW SHALL equal 1 in every cycle except the ACCESS cycle of a write, so memory is never written outside ACCESS.
REQ-027 RDATA SHALL hold its last read value until the next read completes.

Reset
REQ-028 While RST=1 at an edge: state<=IDLE, MEN<=0, MRW<=1, MA<=0, MWD<=0, ACK0<=0, ACK1<=0, RDATA<=0, LAST<=1 (port 0 wins the first tie).
REQ-029 RST asserted in ACCESS or RESP SHALL abort the access: no ACK issued, RDATA not updated, and no further memory strobe.
REQ-030 Requests SHALL be honoured from the first edge after RST deasserts.

Verification
REQ-031 Single read: memory[0x0010]=0xBEEF; REQ0=1, WE0=0, ADDR0=0x0010 -> MEN=1, MRW=1, MA=0x0010 for one cycle; ACK0 3 cycles after sampling; RDATA=0xBEEF; ACK1 never high.
REQ-032 Write then readback: port 1 writes 0x1234 to 0x00FF -> single MEN cycle with MRW=0 and MWD=0x1234; a following port 1 read of 0x00FF -> RDATA=0x1234.
REQ-033 Simultaneous requests after reset: REQ0=REQ1=1 held continuously -> ACK order 0,1,0,1, each 3 cycles apart, MA alternating between ADDR0 and ADDR1.
REQ-034 REQ held through ACK: REQ0 high for one extra cycle after ACK0 -> no second access to port 0; a pending REQ1 is granted instead.
REQ-035 Reset mid-access: RST pulsed during the ACCESS cycle of a port 0 read -> no ACK0, RDATA stays 0, MEN=0, state IDLE; REQ0 still high afterwards -> served normally with a 3-cycle latency.
REQ-036 Idle stability: no requests for 20 cycles -> MEN=0, MRW=1, both ACKs low throughout.
